// File: rtl/prefix_addsub_pipe_if.sv
// rtl/prefix_addsub_pipe_if.sv - operand/result handshake bundle for prefix_addsub_pipe
//
// Purpose: groups the operand (in_*) and result (out_*) handshakes of the
// pipelined prefix adder/subtractor so producer and consumer share one port.
// Ports (WIDTH = operand width):
//   in_valid  producer -> adder   operands valid
//   in_ready  adder -> producer   adder accepts operands this cycle
//   op_sub    producer -> adder   0: a+b, 1: a-b
//   a, b      producer -> adder   operands, WIDTH bits
//   out_valid adder -> consumer   result valid
//   out_ready consumer -> adder   consumer accepts result
//   sum       adder -> consumer   result mod 2^WIDTH
//   cout      adder -> consumer   carry out (sub: 1 = no borrow)
//   zero/neg/ovf                  status flags of the registered sum
// master = operand source / result sink, slave = the adder.
interface prefix_addsub_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             zero;
   logic             neg;
   logic             ovf;

   modport master (
      output in_valid, op_sub, a, b, out_ready,
      input  in_ready, out_valid, sum, cout, zero, neg, ovf
   );

   modport slave (
      input  in_valid, op_sub, a, b, out_ready,
      output in_ready, out_valid, sum, cout, zero, neg, ovf
   );
endinterface

// File: rtl/prefix_addsub_pipe.sv
// rtl/prefix_addsub_pipe.sv - pipelined Kogge-Stone adder/subtractor with valid/ready
//
// Purpose: registered a+b / a-b datapath. Stage 0 forms generate/propagate,
// NPR prefix groups of LVLS_PER levels each end in a register, and the output
// stage forms sum and flags. Latency = ceil(clog2(WIDTH)/LVLS_PER) + 2.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   io     prefix_addsub_pipe_if.slave (operand and result handshakes)
// The whole pipeline advances or holds as one unit; it holds only while a
// valid result is waiting on a deasserted out_ready.
module prefix_addsub_pipe #(
   parameter int WIDTH    = 16,
   parameter int LVLS_PER = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   prefix_addsub_pipe_if.slave io
);
   localparam int L   = $clog2(WIDTH);
   localparam int NPR = (L + LVLS_PER - 1) / LVLS_PER;

   // Group generate for one prefix level of span 2^k. Positions whose partner
   // is already fully resolved (gray cells) and the rest (black cells) share
   // the same generate equation.
   function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g,
                                             input logic [WIDTH-1:0] p,
                                             input int k);
      logic [WIDTH-1:0] gn;
      gn = g;
      for (int i = (1 << k); i < WIDTH; i++) begin
         gn[i] = g[i] | (p[i] & g[i - (1 << k)]);
      end
      return gn;
   endfunction

   // Group propagate is only refreshed by black cells (partner unresolved).
   function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p,
                                             input int k);
      logic [WIDTH-1:0] pn;
      pn = p;
      for (int i = (2 << k); i < WIDTH; i++) begin
         pn[i] = p[i] & p[i - (1 << k)];
      end
      return pn;
   endfunction

   logic stall;
   logic adv;
   assign stall       = io.out_valid & ~io.out_ready;
   assign adv         = ~stall;
   assign io.in_ready = adv;

   // Stage registers, index 0 = operand stage, NPR = last prefix group.
   logic [NPR:0][WIDTH-1:0]   g_q;    // group generate
   logic [NPR-1:0][WIDTH-1:0] pp_q;   // group propagate, dead after the last level
   logic [NPR:0][WIDTH-1:0]   p_q;    // bitwise propagate, kept for the sum
   logic [NPR:0]              cin_q;
   logic [NPR:0]              am_q;   // a[W-1]
   logic [NPR:0]              bm_q;   // bi[W-1]
   logic [NPR:0]              v_q;

   logic [WIDTH-1:0] bi;
   logic [WIDTH-1:0] g0;
   logic [WIDTH-1:0] p0;

   always_comb begin
      bi    = io.op_sub ? ~io.b : io.b;
      p0    = io.a ^ bi;
      g0    = io.a & bi;
      // Carry-in sits at position -1, so bit 0 absorbs it before the tree.
      g0[0] = g0[0] | (p0[0] & io.op_sub);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q[0]   <= 1'b0;
         g_q[0]   <= '0;
         pp_q[0]  <= '0;
         p_q[0]   <= '0;
         cin_q[0] <= 1'b0;
         am_q[0]  <= 1'b0;
         bm_q[0]  <= 1'b0;
      end else if (adv) begin
         v_q[0] <= io.in_valid;
         if (io.in_valid) begin
            g_q[0]   <= g0;
            pp_q[0]  <= p0;
            p_q[0]   <= p0;
            cin_q[0] <= io.op_sub;
            am_q[0]  <= io.a[WIDTH-1];
            bm_q[0]  <= bi[WIDTH-1];
         end
      end
   end

   for (genvar j = 1; j <= NPR; j++) begin : g_grp
      localparam int KLO  = (j - 1) * LVLS_PER;
      localparam int NL   = (L - KLO < LVLS_PER) ? (L - KLO) : LVLS_PER;
      localparam bit LAST = (j == NPR);
      // The final level of the tree never needs its propagate output.
      localparam int NP   = LAST ? NL - 1 : NL;

      logic [NL:0][WIDTH-1:0] lg;
      logic [NP:0][WIDTH-1:0] lp;

      assign lg[0] = g_q[j-1];
      assign lp[0] = pp_q[j-1];

      for (genvar m = 0; m < NL; m++) begin : g_lvl
         assign lg[m+1] = ks_g(lg[m], lp[m], KLO + m);
         if (m < NP) begin : g_prop
            assign lp[m+1] = ks_p(lp[m], KLO + m);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q[j]   <= 1'b0;
            g_q[j]   <= '0;
            p_q[j]   <= '0;
            cin_q[j] <= 1'b0;
            am_q[j]  <= 1'b0;
            bm_q[j]  <= 1'b0;
         end else if (adv) begin
            v_q[j] <= v_q[j-1];
            if (v_q[j-1]) begin
               g_q[j]   <= lg[NL];
               p_q[j]   <= p_q[j-1];
               cin_q[j] <= cin_q[j-1];
               am_q[j]  <= am_q[j-1];
               bm_q[j]  <= bm_q[j-1];
            end
         end
      end

      if (!LAST) begin : g_pp
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pp_q[j] <= '0;
            end else if (adv && v_q[j-1]) begin
               pp_q[j] <= lp[NL];
            end
         end
      end
   end

   // G[i] now holds the carry out of bit i, carry-in included.
   logic [WIDTH-1:0] g_f;
   logic [WIDTH-1:0] sum_n;
   assign g_f   = g_q[NPR];
   assign sum_n = p_q[NPR] ^ {g_f[WIDTH-2:0], cin_q[NPR]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io.out_valid <= 1'b0;
         io.sum       <= '0;
         io.cout      <= 1'b0;
         io.zero      <= 1'b0;
         io.neg       <= 1'b0;
         io.ovf       <= 1'b0;
      end else if (adv) begin
         io.out_valid <= v_q[NPR];
         // Results and flags keep their last value across bubbles.
         if (v_q[NPR]) begin
            io.sum  <= sum_n;
            io.cout <= g_f[WIDTH-1];
            io.zero <= ~|sum_n;
            io.neg  <= sum_n[WIDTH-1];
            io.ovf  <= (am_q[NPR] == bm_q[NPR]) && (sum_n[WIDTH-1] != am_q[NPR]);
         end
      end
   end
endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// tb/tb_prefix_addsub_pipe.sv - self-checking bench for prefix_addsub_pipe
module tb_prefix_addsub_pipe;
   localparam int W   = 16;
   localparam int LAT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prefix_addsub_pipe_if #(.WIDTH(W)) io ();
   prefix_addsub_pipe #(.WIDTH(W), .LVLS_PER(2)) dut (.clk(clk), .rst_n(rst_n), .io(io));

   // Latency sweep over other geometries: one full-ripple add each (1 + all ones).
   localparam int SW [3] = '{8, 32, 64};
   localparam int SL [3] = '{1, 3, 3};
   for (genvar c = 0; c < 3; c++) begin : g_sw
      localparam int CW = SW[c];
      prefix_addsub_pipe_if #(.WIDTH(CW)) sio ();
      prefix_addsub_pipe #(.WIDTH(CW), .LVLS_PER(SL[c])) sdut (.clk(clk), .rst_n(rst_n), .io(sio));
      int lat  = -1;
      bit ok   = 1'b0;
      bit done = 1'b0;
      initial begin
         int n;
         n = 0;
         sio.in_valid = 1'b0; sio.op_sub = 1'b0; sio.a = '0; sio.b = '0; sio.out_ready = 1'b1;
         wait (rst_n === 1'b1);
         @(negedge clk);
         sio.in_valid = 1'b1; sio.a = CW'(1); sio.b = '1;
         @(posedge clk);
         n = 1;
         @(negedge clk);
         sio.in_valid = 1'b0;
         while (!sio.out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
         end
         if (sio.out_valid) begin
            lat = n;
            ok  = (sio.sum == '0) && sio.cout && sio.zero && !sio.neg;
         end
         done = 1'b1;
      end
   end

   typedef struct {
      logic [W-1:0] sum;
      logic         cout, zero, neg, ovf;
      int           acc;
      bit           chk_lat;
   } exp_t;

   typedef struct {
      logic         sub;
      logic [W-1:0] a, b, sum;
      logic         cout, zero, neg, ovf;
   } vec_t;

   exp_t q[$];
   vec_t tbl [8];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_out   = 0;
   int   cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_res(input string name, input logic [W+3:0] act, input logic [W+3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [W+3:0] pack(input exp_t e);
      return {e.sum, e.cout, e.zero, e.neg, e.ovf};
   endfunction

   function automatic logic [W+3:0] dut_word();
      return {io.sum, io.cout, io.zero, io.neg, io.ovf};
   endfunction

   // Integer reference: unsigned result for sum/cout, signed result for ovf.
   function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int ua, ub, us, sa, sb, ss;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      us = sub ? ua - ub : ua + ub;
      ss = sub ? sa - sb : sa + sb;
      e.sum     = us[W-1:0];
      e.cout    = sub ? (ua >= ub) : (us >= (1 << W));
      e.zero    = (e.sum == '0);
      e.neg     = e.sum[W-1];
      e.ovf     = (ss > 32767) || (ss < -32768);
      e.acc     = 0;
      e.chk_lat = 1'b0;
      return e;
   endfunction

   task automatic collect();
      exp_t e;
      if (io.out_valid && io.out_ready) begin
         n_out++;
         if (q.size() == 0) begin
            check_bit("unexpected_output", 1'b1, 1'b0);
         end else begin
            e = q.pop_front();
            check_res("result", dut_word(), pack(e));
            if (e.chk_lat) check_int("latency", cyc - e.acc, LAT - 1);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      collect();
   endtask

   task automatic drive(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input bit chk);
      io.in_valid = 1'b1;
      io.op_sub   = sub;
      io.a        = a;
      io.b        = b;
      #1;
      if (io.in_ready) begin
         e.acc     = cyc + 1;
         e.chk_lat = chk;
         q.push_back(e);
      end
   endtask

   task automatic idle();
      io.in_valid = 1'b0;
   endtask

   initial begin
      exp_t e;
      int   ir_bad, n0, k;
      logic sub;
      logic [W-1:0] ra, rb;

      tbl[0] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[1] = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};

      io.in_valid = 1'b0; io.op_sub = 1'b0; io.a = '0; io.b = '0; io.out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check_bit("reset_out_valid", io.out_valid, 1'b0);
      check_res("reset_outputs", dut_word(), '0);
      check_bit("reset_in_ready", io.in_ready, 1'b1);
      rst_n = 1'b1;

      // Directed table, one op at a time, latency checked
      for (int i = 0; i < 8; i++) begin
         step();
         e.sum = tbl[i].sum; e.cout = tbl[i].cout; e.zero = tbl[i].zero;
         e.neg = tbl[i].neg; e.ovf = tbl[i].ovf;
         drive(tbl[i].sub, tbl[i].a, tbl[i].b, e, 1'b1);
         repeat (LAT + 2) begin step(); idle(); end
      end
      check_int("table_drain", q.size(), 0);

      // Back-to-back random stream, no backpressure
      ir_bad = 0;
      n0 = n_out;
      for (int i = 0; i < 100; i++) begin
         step();
         if (io.in_ready !== 1'b1) ir_bad++;
         sub = 1'($urandom_range(0, 1));
         ra  = W'($urandom);
         rb  = W'($urandom);
         if (i % 10 == 3) rb = ra;
         drive(sub, ra, rb, model(sub, ra, rb), 1'b1);
      end
      repeat (LAT + 2) begin step(); idle(); end
      check_int("stream_in_ready_drops", ir_bad, 0);
      check_int("stream_count", n_out - n0, 100);
      check_int("stream_drain", q.size(), 0);

      // Backpressure: 4 ops in flight, out_ready low for 6 cycles
      n0 = n_out;
      io.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         ra = W'(16'h1000 * (i + 1) + i);
         rb = W'(16'h0F00 + 3 * i);
         drive(i[0], ra, rb, model(i[0], ra, rb), 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         check_bit("stall_in_ready", io.in_ready, 1'b0);
         check_bit("stall_out_valid", io.out_valid, 1'b1);
         check_res("stall_hold", dut_word(), pack(q[0]));
         drive(1'b0, 16'h1111, 16'h2222, model(1'b0, 16'h1111, 16'h2222), 1'b0);
      end
      io.out_ready = 1'b1;
      idle();
      collect();
      repeat (LAT + 6) begin step(); idle(); end
      check_int("stall_delivered", n_out - n0, 4);
      check_int("stall_drain", q.size(), 0);

      // Geometry sweep results
      k = 0;
      while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_bit("sweep_done", g_sw[0].done && g_sw[1].done && g_sw[2].done, 1'b1);
      check_int("lat_w8_l1", g_sw[0].lat, 5);
      check_int("lat_w32_l3", g_sw[1].lat, 4);
      check_int("lat_w64_l3", g_sw[2].lat, 4);
      check_bit("sum_w8_l1", g_sw[0].ok, 1'b1);
      check_bit("sum_w32_l3", g_sw[1].ok, 1'b1);
      check_bit("sum_w64_l3", g_sw[2].ok, 1'b1);

      // Reset with 3 ops in flight
      io.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         drive(1'b0, 16'h7FFF, W'(i + 1), model(1'b0, 16'h7FFF, W'(i + 1)), 1'b0);
      end
      step(); idle();
      step();
      check_bit("prereset_out_valid", io.out_valid, 1'b1);
      check_res("prereset_word", dut_word(), 20'h80003);
      rst_n = 1'b0;
      #1;
      check_bit("midreset_out_valid", io.out_valid, 1'b0);
      check_res("midreset_outputs", dut_word(), '0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      io.out_ready = 1'b1;
      n0 = n_out;
      repeat (LAT + 6) begin step(); idle(); end
      check_int("postreset_outputs", n_out - n0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
